dm_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline's MEM stage (CPU) and a DMA/bridge requester, and sequences a word-by-word clear of the memory after reset. Sits between the MEM stage and the byte-enabled data memory: it drives the memory's address, write-data and byte-enable inputs. It returns read data to the owning requester and stalls the CPU when the port is busy. Arbitration is round-robin, one access per cycle.

---
 rtl/dm_arbiter_pkg.sv | 17 +
 rtl/dm_rr_arb.sv | 48 ++++
 rtl/dm_arbiter.sv | 129 ++++++++++++
 tb/tb_dm_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dm_arbiter_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefDepth = 4096;

  typedef enum logic {
    StClear,
    StRun
  } state_e;

  typedef enum logic {
    ReqCpu,
    ReqDma
  } req_e;

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter (CPU vs DMA) holding the most-recent-grant register.
module dm_rr_arb
  import dm_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_cpu_i,
  input  logic req_dma_i,
  output logic gnt_cpu_o,
  output logic gnt_dma_o
);

  req_e last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_cpu_o = 1'b0;
    gnt_dma_o = 1'b0;
    if (en_i) begin
      if (req_cpu_i && req_dma_i) begin
        // On a tie the side that lost most recently wins.
        gnt_cpu_o = (last_gnt_q == ReqDma);
        gnt_dma_o = (last_gnt_q == ReqCpu);
      end else begin
        gnt_cpu_o = req_cpu_i;
        gnt_dma_o = req_dma_i;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_cpu_o) begin
      last_gnt_d = ReqCpu;
    end else if (gnt_dma_o) begin
      last_gnt_d = ReqDma;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_gnt_q <= ReqDma;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU/DMA round-robin plus optional post-reset clear.
// Define DM_CLEAR_EN to compile in the clear engine that zeroes memory after reset.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW,
  parameter int unsigned Depth = DefDepth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [3:0]       cpu_be_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  input  logic             dma_req_i,
  input  logic             dma_we_i,
  input  logic [AddrW-1:0] dma_addr_i,
  input  logic [3:0]       dma_be_i,
  input  logic [31:0]      dma_wdata_i,
  output logic             dma_gnt_o,
  output logic             dma_rvalid_o,
  output logic [31:0]      dma_rdata_o,
  output logic             busy_o,
  output logic [AddrW-1:0] dm_addr_o,
  output logic [31:0]      dm_wdata_o,
  output logic [3:0]       dm_be_o,
  input  logic [31:0]      dm_rdata_i
);

  if (Depth == 0 || Depth > (1 << AddrW)) begin : g_depth_chk
    $error("dm_arbiter: Depth must be in 1 .. 2**AddrW");
  end

  logic             clearing;
  logic [AddrW-1:0] clr_addr;
  logic             gnt_cpu, gnt_dma;

`ifdef DM_CLEAR_EN
  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AddrW'(Depth - 1)) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    clearing = (state_q == StClear);
    clr_addr = clr_cnt_q;
  end
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  dm_rr_arb u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (!clearing),
    .req_cpu_i (cpu_req_i),
    .req_dma_i (dma_req_i),
    .gnt_cpu_o (gnt_cpu),
    .gnt_dma_o (gnt_dma)
  );

  always_comb begin
    dm_addr_o  = cpu_addr_i;
    dm_wdata_o = 32'h0;
    dm_be_o    = 4'h0;
    if (clearing) begin
      dm_addr_o = clr_addr;
      dm_be_o   = 4'hF;
    end else if (gnt_cpu) begin
      dm_addr_o  = cpu_addr_i;
      dm_wdata_o = cpu_wdata_i;
      dm_be_o    = cpu_we_i ? cpu_be_i : 4'h0;
    end else if (gnt_dma) begin
      dm_addr_o  = dma_addr_i;
      dm_wdata_o = dma_wdata_i;
      dm_be_o    = dma_we_i ? dma_be_i : 4'h0;
    end
  end

  assign busy_o      = clearing;
  assign cpu_rdata_o = dm_rdata_i;
  assign cpu_stall_o = cpu_req_i & ~gnt_cpu;
  assign dma_gnt_o   = gnt_dma;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt_dma & ~dma_we_i;
    rdata_d  = rvalid_d ? dm_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dma_rvalid_o = rvalid_q;
  assign dma_rdata_o  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: per-cycle model compare plus directed literal checks.
module tb_dm_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
`ifdef DM_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic          clk, rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [3:0]    cpu_be, dma_be;
  logic [31:0]   cpu_wdata, dma_wdata, mem_rdata;
  logic [31:0]   cpu_rdata, dma_rdata, dm_wdata;
  logic          cpu_stall, dma_gnt, dma_rvalid, busy;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_be;

  int errors = 0;
  int checks = 0;

  dm_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_be_i     (cpu_be),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .dma_req_i    (dma_req),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_be_i     (dma_be),
    .dma_wdata_i  (dma_wdata),
    .dma_gnt_o    (dma_gnt),
    .dma_rvalid_o (dma_rvalid),
    .dma_rdata_o  (dma_rdata),
    .busy_o       (busy),
    .dm_addr_o    (dm_addr),
    .dm_wdata_o   (dm_wdata),
    .dm_be_o      (dm_be),
    .dm_rdata_i   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Model: words still to clear, who won last, pending DMA read return.
  int          clr_idx;
  bit          last_cpu;
  bit          m_valid = 1'b0;
  bit          e_rv;
  logic [31:0] e_rd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1'b1;
      clr_idx  = ClrEn ? 0 : DEPTH;
      last_cpu = 1'b0;
      e_rv     = 1'b0;
      e_rd     = 32'h0;
    end
  end

  always @(negedge clk) begin
    bit          clr, cw, dw;
    logic [AW-1:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    if (rst_n && m_valid) begin
      clr    = (clr_idx < DEPTH);
      cw     = !clr && cpu_req && (!dma_req || !last_cpu);
      dw     = !clr && dma_req && !cw;
      e_addr = cpu_addr;
      e_be   = 4'h0;
      e_wd   = 32'h0;
      if (clr) begin
        e_addr = AW'(clr_idx);
        e_be   = 4'hF;
      end else if (cw) begin
        e_wd = cpu_wdata;
        e_be = cpu_we ? cpu_be : 4'h0;
      end else if (dw) begin
        e_addr = dma_addr;
        e_wd   = dma_wdata;
        e_be   = dma_we ? dma_be : 4'h0;
      end
      chk("m_busy", busy, clr);
      chk("m_stall", cpu_stall, cpu_req && !cw);
      chk("m_dma_gnt", dma_gnt, dw);
      chk("m_dm_addr", dm_addr, e_addr);
      chk("m_dm_be", dm_be, e_be);
      chk("m_dm_wdata", dm_wdata, e_wd);
      chk("m_cpu_rdata", cpu_rdata, mem_rdata);
      chk("m_dma_rvalid", dma_rvalid, e_rv);
      chk("m_dma_rdata", dma_rdata, e_rd);
      if (clr) clr_idx++;
      if (cw) last_cpu = 1'b1;
      if (dw) last_cpu = 1'b0;
      e_rv = dw && !dma_we;
      if (e_rv) e_rd = mem_rdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit exp_g[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_rv[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_be = '0; dma_wdata = '0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cpu_req = 1'b1;
`ifdef DM_CLEAR_EN
    @(negedge clk);
    chk("clr_busy0", busy, 1'b1);
    chk("clr_stall0", cpu_stall, 1'b1);
    chk("clr_addr0", dm_addr, 12'h000);
    repeat (DEPTH - 1) @(negedge clk);
    chk("clr_addr_last", dm_addr, 12'hFFF);
    chk("clr_be_last", dm_be, 4'hF);
    @(negedge clk);
    chk("run_busy", busy, 1'b0);
    chk("run_stall", cpu_stall, 1'b0);
`else
    dma_req = 1'b1;
    @(negedge clk);
    chk("noclr_busy", busy, 1'b0);
    chk("noclr_dma_gnt", dma_gnt, 1'b0);
    chk("noclr_stall", cpu_stall, 1'b0);
`endif
    // CPU store with partial byte enables
    cyc();
    dma_req = 0;
    cpu_we = 1; cpu_addr = 12'h010; cpu_be = 4'b0011; cpu_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_be", dm_be, 4'b0011);
    chk("st_addr", dm_addr, 12'h010);
    chk("st_stall", cpu_stall, 1'b0);
    chk("st_wdata", dm_wdata, 32'h12345678);
    // DMA-only load so the next tie goes to the CPU
    cyc();
    cpu_req = 0; cpu_we = 0;
    dma_req = 1; dma_we = 0; dma_addr = 12'h123; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("dma_only_gnt", dma_gnt, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      cpu_req   = 1;
      cpu_addr  = AW'(12'h040 + k);
      mem_rdata = 32'h1000_0000 + k;
      @(negedge clk);
      chk("alt_gnt", dma_gnt, exp_g[k]);
      chk("alt_stall", cpu_stall, exp_g[k]);
      chk("alt_rvalid", dma_rvalid, exp_rv[k]);
      if (k == 2) chk("alt_rdata", dma_rdata, 32'h1000_0001);
    end
    cyc();
    cpu_req = 0; dma_req = 0;
    @(negedge clk);
    chk("alt_tail_rvalid", dma_rvalid, 1'b1);
    chk("alt_tail_rdata", dma_rdata, 32'h1000_0003);
    // DMA load from 0x7FF
    cyc();
    dma_req = 1; dma_we = 0; dma_addr = 12'h7FF; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_gnt", dma_gnt, 1'b1);
    chk("ld_addr", dm_addr, 12'h7FF);
    chk("ld_be", dm_be, 4'h0);
    cyc();
    dma_req = 0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("ld_rvalid", dma_rvalid, 1'b1);
    chk("ld_rdata", dma_rdata, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("ld_rvalid_drop", dma_rvalid, 1'b0);
    chk("ld_rdata_hold", dma_rdata, 32'hDEADBEEF);
    // DMA store with be=0 is forwarded and never returns data
    cyc();
    dma_req = 1; dma_we = 1; dma_be = 4'h0; dma_addr = 12'h055; dma_wdata = 32'hAAAA5555;
    @(negedge clk);
    chk("st0_be", dm_be, 4'h0);
    chk("st0_wdata", dm_wdata, 32'hAAAA5555);
    chk("st0_gnt", dma_gnt, 1'b1);
    cyc();
    dma_be = 4'hC;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h321; cpu_be = 4'hF; cpu_wdata = 32'h0BADF00D;
    @(negedge clk);
    chk("st0_rvalid", dma_rvalid, 1'b0);
    chk("tie_cpu_st", dm_be, 4'hF);
    cyc();
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("tie_dma_st", dm_be, 4'hC);
    // Reset during a granted DMA load drops its rvalid
    cyc();
    dma_we = 0; dma_addr = 12'h200; mem_rdata = 32'h55AA55AA;
    rst_n = 0;
    cyc();
    rst_n = 1; dma_req = 0;
    @(negedge clk);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, 32'h0);
`ifdef DM_CLEAR_EN
    repeat (100) @(negedge clk);
    chk("mid_addr100", dm_addr, 12'h064);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("restart_addr", dm_addr, 12'h000);
    chk("restart_busy", busy, 1'b1);
    repeat (DEPTH - 1) @(negedge clk);
    chk("restart_busy_last", busy, 1'b1);
    @(negedge clk);
    chk("restart_done", busy, 1'b0);
`endif
    // First tie after reset goes to the CPU
    cyc();
    cpu_req = 1; cpu_we = 0; dma_req = 1; dma_we = 0;
    @(negedge clk);
    chk("first_tie_dma", dma_gnt, 1'b0);
    chk("first_tie_stall", cpu_stall, 1'b0);
    cyc();
    @(negedge clk);
    chk("second_tie_dma", dma_gnt, 1'b1);
    cyc();
    cpu_req = 0; dma_req = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
